// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path.
// Contents: FSM state encoding, opcode/funct constants and ALU op codes.
package ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        StIdle    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAdr  = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StRtypeEx = 4'd7,
        StRtypeWb = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StBranch  = 4'd11,
        StJump    = 4'd12
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU op codes
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder.
// Ports:
//   funct          in   6         IR[5:0]
//   alu_op         out  ALU_OP_W  ALU op for the funct (0 when unsupported)
//   illegal_funct  out  1         funct is not a supported R-type operation
module alu_decoder
    import ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic [5:0]          funct,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal_funct
);

    always_comb begin
        alu_op        = '0;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_OP_W'(ALU_ADD);
            FN_SUB:  alu_op = ALU_OP_W'(ALU_SUB);
            FN_AND:  alu_op = ALU_OP_W'(ALU_AND);
            FN_OR:   alu_op = ALU_OP_W'(ALU_OR);
            FN_NOR:  alu_op = ALU_OP_W'(ALU_NOR);
            FN_SLT:  alu_op = ALU_OP_W'(ALU_SLT);
            default: illegal_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM. Sequences fetch/decode/execute/memory/
// writeback and drives every datapath enable and mux select.
// Ports:
//   clock, reset (async, active-high)
//   opcode, funct        instruction fields from the IR
//   zero                 ALU zero flag (branch resolution)
//   mem_ready            memory finished the current access this cycle
//   pc_write_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, alu_src_a, alu_src_b, pc_src, alu_op   datapath controls
//   illegal              one-cycle pulse on unsupported opcode/funct
//   retired              count of completed instructions (wraps)
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write_en,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   retired_q;
    logic               pc_write, branch, retire;
    logic [ALU_OP_W-1:0] dec_alu_op;
    logic               dec_illegal;

    alu_decoder #(
        .ALU_OP_W (ALU_OP_W)
    ) u_alu_decoder (
        .funct         (funct),
        .alu_op        (dec_alu_op),
        .illegal_funct (dec_illegal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        branch     = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        pc_src     = 2'd0;
        alu_op     = '0;
        illegal    = 1'b0;
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                alu_op    = ALU_OP_W'(ALU_ADD);
                // Qualified so the IR loads and PC advances exactly once per fetch.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                alu_src_b = 2'd3;
                alu_op    = ALU_OP_W'(ALU_ADD);
                case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StRtypeEx;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALU_OP_W'(ALU_ADD);
                state_d   = (opcode == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                i_or_d    = 1'b1;
                // Dropped in the completing cycle so the store is not repeated.
                mem_write = ~mem_ready;
                if (mem_ready) state_d = StFetch;
            end
            StRtypeEx: begin
                alu_src_a = 1'b1;
                alu_op    = dec_alu_op;
                if (dec_illegal) begin
                    illegal = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StRtypeWb;
                end
            end
            StRtypeWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALU_OP_W'(ALU_ADD);
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_W'(ALU_SUB);
                branch    = 1'b1;
                pc_src    = 2'd1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                state_d  = StFetch;
            end
            default: state_d = StIdle;
        endcase
        pc_write_en = pc_write | (branch & zero);
    end

    // Only completed instructions count; illegal aborts return to fetch uncounted.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            StMemWb, StMemWr, StRtypeWb, StAddiWb, StBranch, StJump:
                retire = (state_d == StFetch);
            default: retire = 1'b0;
        endcase
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ready;
    logic        pc_write_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
    logic        mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0]  alu_src_b, pc_src;
    logic [3:0]  alu_op;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fails  = 0;

    multicycle_control #(
        .ALU_OP_W (4),
        .CNT_W    (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write_en (pc_write_en),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [17:0] exp;
        logic [31:0] ret;
    } vec_t;

    typedef struct packed {
        logic [17:0] exp;
        logic [31:0] ret;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    // {pwe, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
    //  reg_write, alu_src_a, alu_src_b[1:0], pc_src[1:0], alu_op[3:0], illegal}
    function automatic logic [17:0] mk(input logic pwe, iord, mr, mw, irw, rdst, m2r, rw,
                                       asa, input logic [1:0] asb, psrc,
                                       input logic [3:0] aop, input logic ill);
        return {pwe, iord, mr, mw, irw, rdst, m2r, rw, asa, asb, psrc, aop, ill};
    endfunction

    function automatic logic [17:0] actual();
        return {pc_write_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal};
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic mr, input logic [17:0] e, input logic [31:0] r);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.exp = e; v.ret = r;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [17:0] e, input logic [31:0] r);
        n_checks++;
        if (actual() !== e || retired !== r) begin
            n_fails++;
            $display("FAIL %s: outputs=%b retired=%0d, required outputs=%b retired=%0d",
                     name, actual(), retired, e, r);
        end
        n_checks++;
        if ((reg_write + mem_write + pc_write_en) > 1) begin
            n_fails++;
            $display("FAIL %s exclusive: rw=%b mw=%b pwe=%b, required at most one",
                     name, reg_write, mem_write, pc_write_en);
        end
    endtask

    // Drive one cycle of stimulus after the edge, compare mid-cycle.
    task automatic step(input vec_t v, input string name);
        sb_t s;
        @(posedge clock);
        #1;
        opcode = v.op; funct = v.fn; zero = v.z; mem_ready = v.mr;
        sb.push_back({v.exp, v.ret});
        @(negedge clock);
        if (sb.size() == 0) begin
            n_checks++; n_fails++;
            $display("FAIL %s: scoreboard empty, required one entry", name);
        end else begin
            s = sb.pop_front();
            check(name, s.exp, s.ret);
        end
    endtask

    initial begin
        logic [17:0] e_none, e_f, e_fst, e_d, e_dill, e_ma, e_mrd, e_mwb, e_mwst, e_mw;
        logic [17:0] e_rslt, e_rnor, e_rbad, e_rwb, e_awb, e_brt, e_brn, e_j;
        vec_t fv;

        e_none = '0;
        e_f    = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 4'd2, 0);
        e_fst  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 4'd2, 0);
        e_d    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 4'd2, 0);
        e_dill = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 4'd2, 1);
        e_ma   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 4'd2, 0);
        e_mrd  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0);
        e_mwb  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 4'd0, 0);
        e_mwst = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0);
        e_mw   = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0);
        e_rslt = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd7, 0);
        e_rnor = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd12, 0);
        e_rbad = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 4'd0, 1);
        e_rwb  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 4'd0, 0);
        e_awb  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 4'd0, 0);
        e_brt  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 4'd6, 0);
        e_brn  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 4'd6, 0);
        e_j    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 4'd0, 0);

        // lw: 5 cycles
        add(6'h23, 6'h00, 0, 1, e_f, 0);   add(6'h23, 6'h00, 0, 1, e_d, 0);
        add(6'h23, 6'h00, 0, 1, e_ma, 0);  add(6'h23, 6'h00, 0, 1, e_mrd, 0);
        add(6'h23, 6'h00, 0, 1, e_mwb, 0);
        // slt, nor, then unknown funct
        add(6'h00, 6'h2A, 0, 1, e_f, 1);   add(6'h00, 6'h2A, 0, 1, e_d, 1);
        add(6'h00, 6'h2A, 0, 1, e_rslt, 1); add(6'h00, 6'h2A, 0, 1, e_rwb, 1);
        add(6'h00, 6'h27, 0, 1, e_f, 2);   add(6'h00, 6'h27, 0, 1, e_d, 2);
        add(6'h00, 6'h27, 0, 1, e_rnor, 2); add(6'h00, 6'h27, 0, 1, e_rwb, 2);
        add(6'h00, 6'h3F, 0, 1, e_f, 3);   add(6'h00, 6'h3F, 0, 1, e_d, 3);
        add(6'h00, 6'h3F, 0, 1, e_rbad, 3);
        // beq taken / not taken
        add(6'h04, 6'h00, 1, 1, e_f, 3);   add(6'h04, 6'h00, 1, 1, e_d, 3);
        add(6'h04, 6'h00, 1, 1, e_brt, 3);
        add(6'h04, 6'h00, 0, 1, e_f, 4);   add(6'h04, 6'h00, 0, 1, e_d, 4);
        add(6'h04, 6'h00, 0, 1, e_brn, 4);
        // addi, j
        add(6'h08, 6'h00, 0, 1, e_f, 5);   add(6'h08, 6'h00, 0, 1, e_d, 5);
        add(6'h08, 6'h00, 0, 1, e_ma, 5);  add(6'h08, 6'h00, 0, 1, e_awb, 5);
        add(6'h02, 6'h00, 0, 1, e_f, 6);   add(6'h02, 6'h00, 0, 1, e_d, 6);
        add(6'h02, 6'h00, 0, 1, e_j, 6);
        // unsupported opcode
        add(6'h3F, 6'h00, 0, 1, e_f, 7);   add(6'h3F, 6'h00, 0, 1, e_dill, 7);
        // fetch stall, then sw with 3 stall cycles in MEMWR (7 cycles total)
        add(6'h2B, 6'h00, 0, 0, e_fst, 7);
        add(6'h2B, 6'h00, 0, 1, e_f, 7);   add(6'h2B, 6'h00, 0, 1, e_d, 7);
        add(6'h2B, 6'h00, 0, 1, e_ma, 7);
        add(6'h2B, 6'h00, 0, 0, e_mwst, 7); add(6'h2B, 6'h00, 0, 0, e_mwst, 7);
        add(6'h2B, 6'h00, 0, 0, e_mwst, 7); add(6'h2B, 6'h00, 0, 1, e_mw, 7);
        // lw stalled in MEMRD, interrupted by reset below
        add(6'h23, 6'h00, 0, 1, e_f, 8);   add(6'h23, 6'h00, 0, 1, e_d, 8);
        add(6'h23, 6'h00, 0, 1, e_ma, 8);  add(6'h23, 6'h00, 0, 0, e_mrd, 8);

        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("reset_held", e_none, 0);
        end
        reset = 1'b0;
        #1 check("idle_after_release", e_none, 0);

        foreach (vecs[i]) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-MEMRD: outputs clear before the next edge.
        #2 reset = 1'b1;
        #1 check("async_reset_memrd", e_none, 0);
        repeat (2) begin
            @(negedge clock);
            check("reset_no_writeback", e_none, 0);
        end
        reset = 1'b0;
        fv.op = 6'h00; fv.fn = 6'h00; fv.z = 1'b0; fv.mr = 1'b1; fv.exp = e_f; fv.ret = 0;
        step(fv, "fetch_after_reset");

        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
